// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-wide RAM controller (icache refill + LSB).
package mem_ctrl_pkg;

    localparam int         ADDR_WIDTH     = 32;
    localparam int         DEF_BLK_BYTES  = 64;
    localparam logic [1:0] LEN_B          = 2'd0;
    localparam logic [1:0] LEN_H          = 2'd1;
    localparam logic [1:0] LEN_W          = 2'd2;
    localparam int         IO_BIT_HI      = 17;
    localparam int         IO_BIT_LO      = 16;
    localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_e;

    // Length code 3 is illegal and is treated as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates icache refills and LSB loads/stores onto a byte-wide single-port RAM,
// sequencing one byte per cycle with IO store back-pressure and read rollback.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         BLK_BYTES  = DEF_BLK_BYTES,
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [ADDR_WIDTH-1:0]  mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full,
    input  logic                   rollback,
    input  logic                   ic_req_en,
    input  logic [ADDR_WIDTH-1:0]  ic_ain,
    output logic                   ic_out_en,
    output logic [ADDR_WIDTH-1:0]  ic_aout,
    output logic [8*BLK_BYTES-1:0] ic_dout,
    input  logic                   lsb_req_en,
    input  logic                   lsb_wr,
    input  logic [1:0]             lsb_len,
    input  logic [ADDR_WIDTH-1:0]  lsb_ain,
    input  logic [31:0]            lsb_din,
    output logic                   lsb_done,
    output logic [31:0]            lsb_dout
);

    localparam int                    ICACHE_BLK_WIDTH = 8 * BLK_BYTES;
    localparam int                    CNT_W            = $clog2(BLK_BYTES + 2);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK         = ADDR_WIDTH'(BLK_BYTES - 1);

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            n_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [31:0]                 st_data_q;
    logic [ICACHE_BLK_WIDTH-1:0] blk_q;
    logic [31:0]                 ld_q;

    logic [CNT_W-1:0]            k_d;
    logic [ICACHE_BLK_WIDTH-1:0] blk_d;
    logic [31:0]                 ld_d;
    logic [1:0]                  ld_idx;
    logic [ADDR_WIDTH-1:0]       st_addr;
    logic [7:0]                  st_byte;
    logic                        st_stall;
    logic                        acc_stall;
    logic                        ic_base_unused;

    // In a read state, k_d is the index of the edge now ending relative to acceptance;
    // the byte on mem_din at that edge was addressed two edges earlier.
    assign k_d       = cnt_q + 1'b1;
    assign blk_d     = {mem_din, blk_q[ICACHE_BLK_WIDTH-1:8]};
    assign ld_idx    = 2'(cnt_q - 1'b1);
    assign st_addr   = base_q + ADDR_WIDTH'(cnt_q);
    assign st_byte   = st_data_q[8*cnt_q[1:0] +: 8];
    assign st_stall  = io_buffer_full && (st_addr[IO_BIT_HI:IO_BIT_LO] == IO_BASE_HI);
    assign acc_stall = io_buffer_full && (lsb_ain[IO_BIT_HI:IO_BIT_LO] == IO_BASE_HI);
    assign ic_base_unused = |(ic_ain & OFS_MASK);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ld_d = ld_q;
        ld_d[8*ld_idx +: 8] = mem_din;
    end

    // NOTE: staging registers have no reset; ld_q is cleared in IDLE and blk_q is fully
    // shifted through before either reaches an output.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            ld_q <= '0;
        end else if (state_q == LOAD && cnt_q != '0) begin
            ld_q <= ld_d;
        end
        if (state_q == IFETCH) begin
            blk_q <= blk_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            base_q    <= '0;
            st_data_q <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            ic_out_en <= 1'b0;
            ic_aout   <= '0;
            ic_dout   <= '0;
            lsb_done  <= 1'b0;
            lsb_dout  <= '0;
        end else begin
            ic_out_en <= 1'b0;
            lsb_done  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    mem_wr <= 1'b0;
                    // A pulse cycle is a cooldown so a still-held request is not re-serviced.
                    if (!rollback && !ic_out_en && !lsb_done) begin
                        if (lsb_req_en) begin
                            base_q <= lsb_ain;
                            n_q    <= CNT_W'(len_bytes(lsb_len));
                            cnt_q  <= '0;
                            mem_a  <= lsb_ain;
                            if (lsb_wr) begin
                                state_q   <= STORE;
                                st_data_q <= lsb_din;
                                mem_dout  <= lsb_din[7:0];
                                if (!acc_stall) begin
                                    mem_wr <= 1'b1;
                                    cnt_q  <= CNT_W'(1);
                                end
                            end else begin
                                state_q <= LOAD;
                            end
                        end else if (ic_req_en) begin
                            state_q <= IFETCH;
                            base_q  <= ic_ain & ~OFS_MASK;
                            mem_a   <= ic_ain & ~OFS_MASK;
                            n_q     <= CNT_W'(BLK_BYTES);
                            cnt_q   <= '0;
                        end
                    end
                end
                IFETCH, LOAD: begin
                    if (rollback) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= k_d;
                        if (k_d < n_q) begin
                            mem_a <= base_q + ADDR_WIDTH'(k_d);
                        end
                        if (k_d == n_q + 1'b1) begin
                            state_q <= IDLE;
                            if (state_q == IFETCH) begin
                                ic_out_en <= 1'b1;
                                ic_aout   <= base_q;
                                ic_dout   <= blk_d;
                            end else begin
                                lsb_done <= 1'b1;
                                lsb_dout <= ld_d;
                            end
                        end
                    end
                end
                STORE: begin
                    // Stores are already committed, so rollback is ignored here.
                    if (cnt_q == n_q) begin
                        state_q  <= IDLE;
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                    end else if (st_stall) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_a    <= st_addr;
                        mem_dout <= st_byte;
                        mem_wr   <= 1'b1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 4-byte block and a synchronous-read RAM model.
module tb_mem_ctrl;

    localparam int BLK = 4;

    logic           clk = 1'b0;
    logic           rst_in = 1'b1;
    logic [7:0]     mem_din;
    logic [7:0]     mem_dout;
    logic [31:0]    mem_a;
    logic           mem_wr;
    logic           io_buffer_full = 1'b0;
    logic           rollback = 1'b0;
    logic           ic_req_en = 1'b0;
    logic [31:0]    ic_ain = '0;
    logic           ic_out_en;
    logic [31:0]    ic_aout;
    logic [8*BLK-1:0] ic_dout;
    logic           lsb_req_en = 1'b0;
    logic           lsb_wr = 1'b0;
    logic [1:0]     lsb_len = 2'd0;
    logic [31:0]    lsb_ain = '0;
    logic [31:0]    lsb_din = '0;
    logic           lsb_done;
    logic [31:0]    lsb_dout;

    logic           pre_we = 1'b0;
    logic [17:0]    pre_a = '0;
    logic [7:0]     pre_d = '0;
    logic [7:0]     ram [0:262143];

    int checks = 0;
    int failures = 0;

    mem_ctrl #(.BLK_BYTES(BLK), .IO_BASE_HI(2'b11)) dut (
        .clk(clk), .rst_in(rst_in), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .rollback(rollback), .ic_req_en(ic_req_en), .ic_ain(ic_ain),
        .ic_out_en(ic_out_en), .ic_aout(ic_aout), .ic_dout(ic_dout),
        .lsb_req_en(lsb_req_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
        .lsb_ain(lsb_ain), .lsb_din(lsb_din), .lsb_done(lsb_done), .lsb_dout(lsb_dout)
    );

    always #5 clk = ~clk;

    // RAM: data for the address seen at an edge is presented during the following cycle.
    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic lsb_xfer(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] din, input logic io0, input logic [31:0] io_mask,
                            input logic [31:0] rb_mask, output int done_c, output int pulses,
                            output logic [31:0] wr_mask);
        done_c = -1; pulses = 0; wr_mask = '0;
        lsb_wr = wr; lsb_len = len; lsb_ain = addr; lsb_din = din;
        io_buffer_full = io0; lsb_req_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (mem_wr === 1'b1) wr_mask[c] = 1'b1;
            if (lsb_done === 1'b1) begin
                pulses++;
                if (done_c < 0) done_c = c;
                lsb_req_en = 1'b0;
            end
            io_buffer_full = io_mask[c];
            rollback = rb_mask[c];
        end
        lsb_req_en = 1'b0; io_buffer_full = 1'b0; rollback = 1'b0;
    endtask

    task automatic test_reset();
        poke(18'h01000, 8'hA0); poke(18'h01001, 8'hA1); poke(18'h01002, 8'hA2); poke(18'h01003, 8'hA3);
        poke(18'h01004, 8'h11); poke(18'h01005, 8'h22); poke(18'h01006, 8'h33); poke(18'h01007, 8'h44);
        poke(18'h01008, 8'h55); poke(18'h01009, 8'h66); poke(18'h0100A, 8'h77); poke(18'h0100B, 8'h88);
        poke(18'h02000, 8'h01); poke(18'h02001, 8'h80); poke(18'h02002, 8'hFF); poke(18'h02003, 8'h04);
        @(negedge clk);
        checks++;
        if ({mem_a, mem_dout, mem_wr, ic_out_en, ic_aout, lsb_done, lsb_dout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ic_en=%b ic_aout=%h done=%b lsb_dout=%h want all 0",
                     mem_a, mem_dout, mem_wr, ic_out_en, ic_aout, lsb_done, lsb_dout);
        end
        checks++;
        if (ic_dout !== '0) begin
            failures++;
            $display("FAIL reset_ic_dout: got %h want 0", ic_dout);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_ifetch();
        int pulses = 0;
        int pulse_c = -1;
        logic [31:0] want_a;
        ic_ain = 32'h1006; ic_req_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 4) begin
                want_a = 32'h1004 + 32'(c);
                checks++;
                if (mem_a !== want_a || mem_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL ifetch_addr c=%0d: got a=%h wr=%b want a=%h wr=0", c, mem_a, mem_wr, want_a);
                end
            end
            if (c == 8) begin
                checks++;
                if (mem_a !== 32'h1007 || mem_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL ifetch_idle_hold: got a=%h wr=%b want a=00001007 wr=0", mem_a, mem_wr);
                end
            end
            if (ic_out_en === 1'b1) begin
                pulses++;
                if (pulse_c < 0) pulse_c = c;
                ic_req_en = 1'b0;
            end
        end
        ic_req_en = 1'b0;
        checks++;
        if (pulses != 1 || pulse_c != 5) begin
            failures++;
            $display("FAIL ifetch_pulse: got %0d pulses first at c=%0d want 1 at c=5", pulses, pulse_c);
        end
        checks++;
        if (ic_aout !== 32'h1004) begin
            failures++;
            $display("FAIL ifetch_aout: got %h want 00001004", ic_aout);
        end
        checks++;
        if (ic_dout !== 32'h44332211) begin
            failures++;
            $display("FAIL ifetch_dout: got %h want 44332211", ic_dout);
        end
    endtask

    task automatic test_priority();
        int lsb_p = 0, lsb_c = -1, ic_p = 0, ic_c = -1;
        logic [31:0] a0 = '0, a7 = '0;
        ic_ain = 32'h1002; ic_req_en = 1'b1;
        lsb_wr = 1'b0; lsb_len = 2'd2; lsb_ain = 32'h2000; lsb_req_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) a0 = mem_a;
            if (c == 7) a7 = mem_a;
            if (lsb_done === 1'b1) begin
                lsb_p++; if (lsb_c < 0) lsb_c = c; lsb_req_en = 1'b0;
            end
            if (ic_out_en === 1'b1) begin
                ic_p++; if (ic_c < 0) ic_c = c; ic_req_en = 1'b0;
            end
        end
        lsb_req_en = 1'b0; ic_req_en = 1'b0;
        checks++;
        if (a0 !== 32'h2000 || a7 !== 32'h1000) begin
            failures++;
            $display("FAIL prio_order: got first a=%h ifetch a=%h want 00002000 00001000", a0, a7);
        end
        checks++;
        if (lsb_p != 1 || lsb_c != 5) begin
            failures++;
            $display("FAIL prio_lsb_done: got %0d pulses at c=%0d want 1 at c=5", lsb_p, lsb_c);
        end
        checks++;
        if (lsb_dout !== 32'h04FF8001) begin
            failures++;
            $display("FAIL prio_lsb_dout: got %h want 04ff8001", lsb_dout);
        end
        checks++;
        if (ic_p != 1 || ic_c != 12) begin
            failures++;
            $display("FAIL prio_ic_pulse: got %0d pulses at c=%0d want 1 at c=12", ic_p, ic_c);
        end
        checks++;
        if (ic_dout !== 32'hA3A2A1A0 || ic_aout !== 32'h1000) begin
            failures++;
            $display("FAIL prio_ic_data: got %h @%h want a3a2a1a0 @00001000", ic_dout, ic_aout);
        end
    endtask

    task automatic test_loads();
        int dc, np;
        logic [31:0] wm;
        lsb_xfer(1'b0, 2'd1, 32'h2001, '0, 1'b0, '0, '0, dc, np, wm);
        checks++;
        if (dc != 3 || np != 1 || lsb_dout !== 32'h0000FF80) begin
            failures++;
            $display("FAIL load_half: got done c=%0d pulses=%0d dout=%h want c=3 1 0000ff80", dc, np, lsb_dout);
        end
        lsb_xfer(1'b0, 2'd0, 32'h2002, '0, 1'b0, '0, '0, dc, np, wm);
        checks++;
        if (dc != 2 || np != 1 || lsb_dout !== 32'h000000FF) begin
            failures++;
            $display("FAIL load_byte: got done c=%0d pulses=%0d dout=%h want c=2 1 000000ff", dc, np, lsb_dout);
        end
    endtask

    task automatic test_store_io();
        int dc, np;
        logic [31:0] wm;
        lsb_xfer(1'b1, 2'd2, 32'h30000, 32'hDEADBEEF, 1'b0, 32'h7, '0, dc, np, wm);
        checks++;
        if (dc != 7 || np != 1) begin
            failures++;
            $display("FAIL store_io_done: got c=%0d pulses=%0d want c=7 1", dc, np);
        end
        checks++;
        if (wm !== 32'h71) begin
            failures++;
            $display("FAIL store_io_wr_mask: got %h want 00000071", wm);
        end
        checks++;
        if ({ram[18'h30003], ram[18'h30002], ram[18'h30001], ram[18'h30000]} !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_io_ram: got %h%h%h%h want deadbeef",
                     ram[18'h30003], ram[18'h30002], ram[18'h30001], ram[18'h30000]);
        end
    endtask

    task automatic test_store_nonio();
        int dc, np;
        logic [31:0] wm;
        lsb_xfer(1'b1, 2'd1, 32'h100, 32'h00001234, 1'b1, 32'hFFFFFFFF, '0, dc, np, wm);
        checks++;
        if (dc != 2 || np != 1 || wm !== 32'h3) begin
            failures++;
            $display("FAIL store_nonio: got c=%0d pulses=%0d wr_mask=%h want c=2 1 00000003", dc, np, wm);
        end
        checks++;
        if ({ram[18'h00101], ram[18'h00100]} !== 16'h1234) begin
            failures++;
            $display("FAIL store_nonio_ram: got %h%h want 1234", ram[18'h00101], ram[18'h00100]);
        end
    endtask

    task automatic test_rollback_ifetch();
        int pulses = 0;
        logic [31:0] a3 = '0;
        ic_ain = 32'h1009; ic_req_en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (ic_out_en === 1'b1) pulses++;
            if (c == 2) begin
                rollback = 1'b1; ic_req_en = 1'b0;
            end
            if (c == 3) begin
                a3 = mem_a; rollback = 1'b0;
            end
        end
        checks++;
        if (a3 !== 32'h100A) begin
            failures++;
            $display("FAIL rb_ifetch_idle: got a=%h want 0000100a", a3);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL rb_ifetch_pulse: got %0d pulses want 0", pulses);
        end
        checks++;
        if (ic_dout !== 32'hA3A2A1A0 || ic_aout !== 32'h1000) begin
            failures++;
            $display("FAIL rb_ifetch_hold: got %h @%h want a3a2a1a0 @00001000", ic_dout, ic_aout);
        end
    endtask

    task automatic test_rollback_store();
        int dc, np;
        logic [31:0] wm;
        lsb_xfer(1'b1, 2'd2, 32'h500, 32'h11223344, 1'b0, '0, 32'h7, dc, np, wm);
        checks++;
        if (dc != 4 || np != 1 || wm !== 32'hF) begin
            failures++;
            $display("FAIL rb_store: got c=%0d pulses=%0d wr_mask=%h want c=4 1 0000000f", dc, np, wm);
        end
        checks++;
        if ({ram[18'h503], ram[18'h502], ram[18'h501], ram[18'h500]} !== 32'h11223344) begin
            failures++;
            $display("FAIL rb_store_ram: got %h%h%h%h want 11223344",
                     ram[18'h503], ram[18'h502], ram[18'h501], ram[18'h500]);
        end
    endtask

    task automatic test_reset_mid_load();
        int pulses = 0;
        int first_c = -1;
        lsb_wr = 1'b0; lsb_len = 2'd2; lsb_ain = 32'h2000; lsb_req_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if ({mem_a, mem_dout, mem_wr, ic_out_en, ic_aout, lsb_done, lsb_dout} !== '0 || ic_dout !== '0) begin
                    failures++;
                    $display("FAIL rst_mid_outputs: mem_a=%h wr=%b done=%b lsb_dout=%h ic_dout=%h want all 0",
                             mem_a, mem_wr, lsb_done, lsb_dout, ic_dout);
                end
                rst_in = 1'b0;
            end
            if (lsb_done === 1'b1) begin
                pulses++; if (first_c < 0) first_c = c; lsb_req_en = 1'b0;
            end
            if (c == 1) rst_in = 1'b1;
        end
        lsb_req_en = 1'b0;
        checks++;
        if (pulses != 1 || first_c != 8) begin
            failures++;
            $display("FAIL rst_mid_restart: got %0d pulses at c=%0d want 1 at c=8", pulses, first_c);
        end
        checks++;
        if (lsb_dout !== 32'h04FF8001) begin
            failures++;
            $display("FAIL rst_mid_dout: got %h want 04ff8001", lsb_dout);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ifetch();
        test_priority();
        test_loads();
        test_store_io();
        test_store_nonio();
        test_rollback_ifetch();
        test_rollback_store();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
